veri_bellegi_yanitlayici: RTL and testbench

- Responder side of the core's data-memory interface: a word-organised data RAM behind a valid/ready request channel and a valid/ready response channel.
- Accepts one load or store at a time and inserts a configurable number of wait states.
- Performs byte-lane steering on stores; performs lane extraction and sign/zero extension on loads.
- Reports misaligned, illegal-size and out-of-range accesses on a response error flag instead of touching memory.

---
 rtl/veri_bellegi_yanitlayici_if.sv | 27 ++
 rtl/veri_bellegi_yanitlayici.sv | 173 +++++++++++++++++
 tb/tb_veri_bellegi_yanitlayici.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/veri_bellegi_yanitlayici_if.sv
// Request/response channel between the core's data-memory requester and the
// data RAM responder.
interface veri_bellegi_yanitlayici_if;
  logic        istek_gecerli;
  logic        istek_hazir;
  logic        istek_yaz;
  logic [31:0] istek_adres;
  logic [1:0]  istek_boyut;
  logic        istek_isaretsiz;
  logic [31:0] istek_veri;
  logic        yanit_gecerli;
  logic        yanit_hazir;
  logic [31:0] yanit_veri;
  logic        yanit_hata;

  modport master (
    output istek_gecerli, istek_yaz, istek_adres, istek_boyut, istek_isaretsiz, istek_veri,
    output yanit_hazir,
    input  istek_hazir, yanit_gecerli, yanit_veri, yanit_hata
  );

  modport slave (
    input  istek_gecerli, istek_yaz, istek_adres, istek_boyut, istek_isaretsiz, istek_veri,
    input  yanit_hazir,
    output istek_hazir, yanit_gecerli, yanit_veri, yanit_hata
  );
endinterface

// File: rtl/veri_bellegi_yanitlayici.sv
// Data RAM responder: one access at a time, fixed wait states, byte-lane steering on
// stores, lane extraction with sign/zero extension on loads, error flag on bad accesses.
module veri_bellegi_yanitlayici #(
  parameter int unsigned ADRES_GENISLIK = 10,
  parameter int unsigned BEKLEME        = 2
) (
  input logic                        clk,
  input logic                        reset,
  veri_bellegi_yanitlayici_if.slave  bus
);

  localparam bit         Sifir    = (BEKLEME == 0);
  localparam logic [3:0] SayacIlk = Sifir ? 4'd0 : 4'(BEKLEME - 1);

  typedef enum logic [1:0] {Bos, Bekle, Yanit} durum_e;

  durum_e      durum_q;
  logic [3:0]  sayac_q;
  logic        istek_hazir_q;
  logic        yanit_gecerli_q;
  logic [31:0] yanit_veri_q;
  logic        yanit_hata_q;

  logic        yaz_q;
  logic [31:0] adres_q;
  logic [1:0]  boyut_q;
  logic        isaretsiz_q;
  logic [31:0] veri_q;

  logic [31:0] mem [2**ADRES_GENISLIK];

  // With zero wait states the access happens on the accept edge, so the access
  // path must see the live request rather than the latched copy.
  logic        bos;
  logic        e_yaz;
  logic [31:0] e_adres;
  logic [1:0]  e_boyut;
  logic        e_isaretsiz;
  logic [31:0] e_veri;

  assign bos         = (durum_q == Bos);
  assign e_yaz       = bos ? bus.istek_yaz       : yaz_q;
  assign e_adres     = bos ? bus.istek_adres     : adres_q;
  assign e_boyut     = bos ? bus.istek_boyut     : boyut_q;
  assign e_isaretsiz = bos ? bus.istek_isaretsiz : isaretsiz_q;
  assign e_veri      = bos ? bus.istek_veri      : veri_q;

  logic erisim;
  assign erisim = Sifir ? (bos && bus.istek_gecerli)
                        : ((durum_q == Bekle) && (sayac_q == 4'd0));

  logic hata;
  assign hata = (e_boyut == 2'b11)
             || ((e_boyut == 2'b01) && e_adres[0])
             || ((e_boyut == 2'b10) && (e_adres[1:0] != 2'b00))
             || ((e_adres >> (ADRES_GENISLIK + 2)) != 32'd0);

  logic [ADRES_GENISLIK-1:0] indeks;
  logic [31:0]               okunan;
  logic [7:0]                bayt;
  logic [15:0]               yarim;
  logic [31:0]               yuk_veri;
  logic [31:0]               sonuc;

  assign indeks = e_adres[ADRES_GENISLIK+1:2];
  assign okunan = mem[indeks];
  assign bayt   = okunan[{e_adres[1:0], 3'b000} +: 8];
  assign yarim  = okunan[{e_adres[1], 4'b0000} +: 16];

  always_comb begin
    yuk_veri = okunan;
    case (e_boyut)
      2'b00:   yuk_veri = {{24{~e_isaretsiz & bayt[7]}}, bayt};
      2'b01:   yuk_veri = {{16{~e_isaretsiz & yarim[15]}}, yarim};
      default: yuk_veri = okunan;
    endcase
  end

  assign sonuc = (hata || e_yaz) ? 32'd0 : yuk_veri;

  logic [3:0]  bayt_en;
  logic [31:0] yaz_veri;
  logic        yaz_en;

  always_comb begin
    bayt_en  = 4'b1111;
    yaz_veri = e_veri;
    case (e_boyut)
      2'b00: begin
        bayt_en  = 4'b0001 << e_adres[1:0];
        yaz_veri = {4{e_veri[7:0]}};
      end
      2'b01: begin
        bayt_en  = e_adres[1] ? 4'b1100 : 4'b0011;
        yaz_veri = {2{e_veri[15:0]}};
      end
      default: begin
        bayt_en  = 4'b1111;
        yaz_veri = e_veri;
      end
    endcase
  end

  // Reset on the access edge aborts the store.
  assign yaz_en = erisim && e_yaz && !hata && !reset;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (yaz_en && bayt_en[i]) begin
        mem[indeks][8*i +: 8] <= yaz_veri[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      durum_q         <= Bos;
      sayac_q         <= 4'd0;
      istek_hazir_q   <= 1'b1;
      yanit_gecerli_q <= 1'b0;
      yanit_veri_q    <= 32'd0;
      yanit_hata_q    <= 1'b0;
    end else begin
      case (durum_q)
        Bos: begin
          if (bus.istek_gecerli) begin
            yaz_q         <= bus.istek_yaz;
            adres_q       <= bus.istek_adres;
            boyut_q       <= bus.istek_boyut;
            isaretsiz_q   <= bus.istek_isaretsiz;
            veri_q        <= bus.istek_veri;
            istek_hazir_q <= 1'b0;
            if (Sifir) begin
              yanit_gecerli_q <= 1'b1;
              yanit_veri_q    <= sonuc;
              yanit_hata_q    <= hata;
              durum_q         <= Yanit;
            end else begin
              sayac_q <= SayacIlk;
              durum_q <= Bekle;
            end
          end
        end
        Bekle: begin
          if (sayac_q == 4'd0) begin
            yanit_gecerli_q <= 1'b1;
            yanit_veri_q    <= sonuc;
            yanit_hata_q    <= hata;
            durum_q         <= Yanit;
          end else begin
            sayac_q <= sayac_q - 4'd1;
          end
        end
        Yanit: begin
          if (bus.yanit_hazir) begin
            yanit_gecerli_q <= 1'b0;
            yanit_veri_q    <= 32'd0;
            yanit_hata_q    <= 1'b0;
            istek_hazir_q   <= 1'b1;
            durum_q         <= Bos;
          end
        end
        default: durum_q <= Bos;
      endcase
    end
  end

  assign bus.istek_hazir   = istek_hazir_q;
  assign bus.yanit_gecerli = yanit_gecerli_q;
  assign bus.yanit_veri    = yanit_veri_q;
  assign bus.yanit_hata    = yanit_hata_q;

endmodule

// File: tb/tb_veri_bellegi_yanitlayici.sv
// Bench for the data RAM responder: directed cases plus random traffic against a
// byte-array memory model; a zero-wait-state instance checks the short latency.
module tb_veri_bellegi_yanitlayici;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  veri_bellegi_yanitlayici_if b0 ();
  veri_bellegi_yanitlayici_if b1 ();

  veri_bellegi_yanitlayici #(.ADRES_GENISLIK(10), .BEKLEME(2)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (b0)
  );

  veri_bellegi_yanitlayici #(.ADRES_GENISLIK(10), .BEKLEME(0)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1)
  );

  bit          hedef = 1'b0;
  logic        gecerli = 1'b0;
  logic        yaz = 1'b0;
  logic [31:0] adres = 32'd0;
  logic [1:0]  boyut = 2'd0;
  logic        isaretsiz = 1'b0;
  logic [31:0] veri = 32'd0;
  logic        yhazir = 1'b1;

  assign b0.istek_gecerli   = gecerli && !hedef;
  assign b1.istek_gecerli   = gecerli && hedef;
  assign b0.istek_yaz       = yaz;
  assign b1.istek_yaz       = yaz;
  assign b0.istek_adres     = adres;
  assign b1.istek_adres     = adres;
  assign b0.istek_boyut     = boyut;
  assign b1.istek_boyut     = boyut;
  assign b0.istek_isaretsiz = isaretsiz;
  assign b1.istek_isaretsiz = isaretsiz;
  assign b0.istek_veri      = veri;
  assign b1.istek_veri      = veri;
  assign b0.yanit_hazir     = yhazir;
  assign b1.yanit_hazir     = yhazir;

  logic        o_ih, o_gv, o_h;
  logic [31:0] o_v;
  assign o_ih = hedef ? b1.istek_hazir   : b0.istek_hazir;
  assign o_gv = hedef ? b1.yanit_gecerli : b0.yanit_gecerli;
  assign o_h  = hedef ? b1.yanit_hata    : b0.yanit_hata;
  assign o_v  = hedef ? b1.yanit_veri    : b0.yanit_veri;

  int toplam = 0;
  int bad = 0;

  // Byte-addressed reference memory covering the 4 KiB of dut0.
  logic [7:0] mdl [0:4095];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    toplam++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_err(input logic [31:0] a, input logic [1:0] b);
    return (b == 2'd3) || (b == 2'd1 && (a % 2) != 0) || (b == 2'd2 && (a % 4) != 0)
        || (a >= 32'd4096);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] b,
                                         input bit isz);
    int n = 1 << b;
    logic [31:0] v = 32'd0;
    for (int i = 0; i < n; i++) v = v | (32'(mdl[a + i]) << (8 * i));
    if (!isz && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic m_store(input logic [31:0] a, input logic [1:0] b, input logic [31:0] d);
    int n = 1 << b;
    for (int i = 0; i < n; i++) mdl[a + i] = 8'(d >> (8 * i));
  endtask

  // One full transaction; bp cycles of response backpressure with a stray request
  // driven meanwhile, which must be ignored.
  task automatic islem(input bit sel, input bit yz, input logic [31:0] adr,
                       input logic [1:0] bt, input bit isz, input logic [31:0] vr,
                       input int bp, output logic [31:0] ov, output logic oh);
    int lat;
    @(negedge clk);
    hedef = sel; gecerli = 1'b1; yaz = yz; adres = adr; boyut = bt;
    isaretsiz = isz; veri = vr; yhazir = (bp == 0);
    #1 chk("istek_hazir_bos", o_ih, 1);
    @(posedge clk); #1;
    gecerli = 1'b0; adres = $urandom; veri = $urandom;
    boyut = 2'($urandom); yaz = 1'($urandom); isaretsiz = 1'($urandom);
    chk("istek_hazir_mesgul", o_ih, 0);
    lat = 1;
    while (!o_gv && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("gecikme", lat, sel ? 1 : 3);
    ov = o_v; oh = o_h;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      gecerli = 1'b1; yaz = 1'b1; adres = 32'h10; boyut = 2'd2; veri = $urandom;
      @(posedge clk); #1;
      chk("bp_gecerli", o_gv, 1);
      chk("bp_veri", o_v, ov);
      chk("bp_hata", o_h, oh);
      chk("bp_istek_hazir", o_ih, 0);
    end
    @(negedge clk);
    gecerli = 1'b0; yhazir = 1'b1;
    @(posedge clk); #1;
    chk("el_sikisma_gecerli", o_gv, 0);
    chk("el_sikisma_istek_hazir", o_ih, 1);
    chk("el_sikisma_veri", o_v, 0);
    chk("el_sikisma_hata", o_h, 0);
  endtask

  task automatic mop(input bit yz, input logic [31:0] adr, input logic [1:0] bt,
                     input bit isz, input logic [31:0] vr, input int bp,
                     output logic [31:0] r);
    logic [31:0] v;
    logic        h;
    bit          e;
    logic [31:0] beklenen;
    e = m_err(adr, bt);
    beklenen = (e || yz) ? 32'd0 : m_load(adr, bt, isz);
    islem(1'b0, yz, adr, bt, isz, vr, bp, v, h);
    chk("yanit_hata", h, e);
    chk("yanit_veri", v, beklenen);
    if (!e && yz) m_store(adr, bt, vr);
    r = v;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, a, d, v1;
    logic        h1;
    logic [1:0]  b;
    int          n;

    repeat (3) @(posedge clk);
    #1;
    hedef = 1'b0;
    #1 chk("reset_istek_hazir0", o_ih, 1);
    chk("reset_gecerli0", o_gv, 0);
    chk("reset_veri0", o_v, 0);
    chk("reset_hata0", o_h, 0);
    hedef = 1'b1;
    #1 chk("reset_istek_hazir1", o_ih, 1);
    chk("reset_gecerli1", o_gv, 0);
    hedef = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    mop(1, 32'h10, 2, 0, 32'hDEADBEEF, 0, r);
    mop(0, 32'h10, 2, 0, 0, 0, r);
    chk("word_geri", r, 32'hDEADBEEF);

    mop(1, 32'h10, 2, 0, 32'h11223344, 0, r);
    mop(1, 32'h13, 0, 0, 32'hFFFFFF80, 0, r);
    mop(0, 32'h13, 0, 0, 0, 0, r);
    chk("bayt_isaretli", r, 32'hFFFFFF80);
    mop(0, 32'h13, 0, 1, 0, 0, r);
    chk("bayt_isaretsiz", r, 32'h00000080);
    mop(0, 32'h10, 2, 0, 0, 0, r);
    chk("bayt_sonrasi_word", r, 32'h80223344);

    mop(1, 32'h20, 2, 0, 32'h11117A5A, 0, r);
    mop(1, 32'h22, 1, 0, 32'h00008001, 0, r);
    mop(0, 32'h22, 1, 0, 0, 0, r);
    chk("yarim_isaretli", r, 32'hFFFF8001);
    mop(0, 32'h22, 1, 1, 0, 0, r);
    chk("yarim_isaretsiz", r, 32'h00008001);
    mop(0, 32'h20, 1, 0, 0, 0, r);
    chk("alt_yarim", r, 32'h00007A5A);

    mop(1, 32'h0, 2, 0, 32'hCAFEF00D, 0, r);
    mop(1, 32'h21, 1, 0, 32'h0000BBBB, 0, r);
    mop(1, 32'h22, 2, 0, 32'hCCCCCCCC, 0, r);
    mop(1, 32'h20, 3, 0, 32'hDDDDDDDD, 0, r);
    mop(1, 32'h1000, 2, 0, 32'hEEEEEEEE, 0, r);
    mop(0, 32'h20, 2, 0, 0, 0, r);
    chk("hata_sonrasi_20", r, 32'h80017A5A);
    mop(0, 32'h0, 2, 0, 0, 0, r);
    chk("hata_sonrasi_0", r, 32'hCAFEF00D);
    mop(0, 32'h1000, 2, 0, 0, 0, r);

    mop(0, 32'h13, 0, 1, 0, 5, r);
    chk("bp_yuk", r, 32'h00000080);
    mop(0, 32'h10, 2, 0, 0, 0, r);
    chk("bp_yoksayildi", r, 32'h80223344);

    // Reset on the access edge of a store must abort it.
    mop(1, 32'h40, 2, 0, 32'hAAAA5555, 0, r);
    @(negedge clk);
    hedef = 1'b0; gecerli = 1'b1; yaz = 1'b1; adres = 32'h40; boyut = 2'd2;
    veri = 32'h12345678; yhazir = 1'b1;
    @(posedge clk); #1;
    gecerli = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("bekle_reset_istek_hazir", o_ih, 1);
    chk("bekle_reset_gecerli", o_gv, 0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("bekle_reset_yanit_yok", o_gv, 0);
    end
    mop(0, 32'h40, 2, 0, 0, 0, r);
    chk("bekle_reset_eski", r, 32'hAAAA5555);

    @(negedge clk);
    hedef = 1'b0; gecerli = 1'b1; yaz = 1'b0; adres = 32'h40; boyut = 2'd2;
    isaretsiz = 1'b0; yhazir = 1'b0;
    @(posedge clk); #1;
    gecerli = 1'b0;
    n = 0;
    while (!o_gv && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("yanit_reset_once", o_gv, 1);
    chk("yanit_reset_once_veri", o_v, 32'hAAAA5555);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("yanit_reset_gecerli", o_gv, 0);
    chk("yanit_reset_veri", o_v, 0);
    chk("yanit_reset_istek_hazir", o_ih, 1);
    yhazir = 1'b1;

    islem(1'b1, 1'b1, 32'h8, 2'd2, 1'b0, 32'h0BADCAFE, 0, v1, h1);
    chk("sifir_yaz_hata", h1, 0);
    islem(1'b1, 1'b0, 32'h8, 2'd2, 1'b0, 32'h0, 0, v1, h1);
    chk("sifir_yuk", v1, 32'h0BADCAFE);
    islem(1'b1, 1'b0, 32'hA, 2'd1, 1'b1, 32'h0, 0, v1, h1);
    chk("sifir_yarim", v1, 32'h00000BAD);
    hedef = 1'b0;

    for (int i = 0; i < 128; i++) mop(1, 32'h100 + 4 * i, 2, 0, $urandom, 0, r);
    for (int i = 0; i < 100; i++) begin
      b = 2'($urandom_range(0, 3));
      a = 32'h100 + $urandom_range(0, 511);
      if ($urandom_range(0, 1) == 1) a = a & ~((32'd1 << b) - 1);
      if ($urandom_range(0, 15) == 0) a = $urandom;
      d = $urandom;
      mop(1'($urandom), a, b, 1'($urandom), d, $urandom_range(0, 2), r);
    end

    $display("test done: total=%0d bad=%0d", toplam, bad);
    $finish;
  end

endmodule
